// File: rtl/apb_req_bridge_pkg.sv
// Shared types, default address window and error signature for the
// req/gnt to APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } bridge_state_e;

  localparam logic [31:0] DEF_WIN_BASE  = 32'h1A10_0000;
  localparam logic [31:0] DEF_WIN_MASK  = 32'hFFFE_0000;
  localparam logic [31:0] DEF_ERR_RDATA = 32'hBADA_CCE5;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/apb_req_bridge_if.sv
// APB3 bus bundle (32-bit address/data) with master and slave views.
interface APB_BUS;

  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_req_bridge_timeout_cnt.sv
// Counts ACCESS cycles; expired is high in the last permitted wait cycle.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (TIMEOUT != 0)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_req_bridge.sv
// Single-outstanding req/gnt/rvalid port to APB3 master with address
// window check and PREADY timeout.
module apb_req_bridge
  import apb_bridge_pkg::*;
#(
  parameter logic [31:0] WIN_BASE  = DEF_WIN_BASE,
  parameter logic [31:0] WIN_MASK  = DEF_WIN_MASK,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  APB_BUS.Master      apb_master
);

  bridge_state_e state_q, state_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cnt_clr;
  logic        cnt_en;
  logic        expired;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  assign data_gnt_o = (state_q == IDLE) && data_req_i;

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    // The response pulse trails the RESP state by one cycle.
    rvalid_d = (state_q == RESP);

    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          paddr_d  = data_addr_i;
          pwrite_d = data_we_i;
          pwdata_d = data_wdata_i;
          if (!in_window(data_addr_i, WIN_BASE, WIN_MASK) ||
              (data_we_i && (data_be_i != 4'hF))) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A late PREADY still beats the timeout in the same cycle.
        if (apb_master.pready) begin
          state_d = RESP;
          err_d   = apb_master.pslverr;
          rdata_d = pwrite_q ? 32'h0 : apb_master.prdata;
        end else if (expired) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
  end

  assign cnt_clr = (state_d != ACCESS);
  assign cnt_en  = (state_q == ACCESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign apb_master.psel    = psel_q;
  assign apb_master.penable = penable_q;
  assign apb_master.pwrite  = pwrite_q;
  assign apb_master.paddr   = paddr_q;
  assign apb_master.pwdata  = pwdata_q;

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed bench for apb_req_bridge: the bench plays the APB slave and
// checks latency, APB sequencing, window/be errors, timeout and reset abort.
module tb_apb_req_bridge;
  import apb_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  int checks   = 0;
  int failures = 0;

  APB_BUS apb ();

  apb_req_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .data_req_i    (data_req),
    .data_addr_i   (data_addr),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_wdata_i  (data_wdata),
    .data_gnt_o    (data_gnt),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .data_err_o    (data_err),
    .apb_master    (apb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request at a negedge (cycle 0 = gnt cycle) and acts as a
  // slave that raises pready in ACCESS cycle number 'waits' (0-based).
  task automatic run_txn(input string name, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] wd, input int waits,
                         input logic [31:0] srd, input logic serr, input int exp_lat,
                         input int exp_acc, input logic [31:0] exp_rd, input logic exp_err);
    int   k;
    int   acc;
    logic done;
    logic setup_seen;
    logic addr_ok;
    logic wd_ok;
    logic wr_ok;
    logic [31:0] got_rd;
    logic        got_err;
    k = 0; acc = 0; done = 1'b0; setup_seen = 1'b0;
    addr_ok = 1'b1; wd_ok = 1'b1; wr_ok = 1'b1;
    got_rd = 32'h0; got_err = 1'b0;
    @(negedge clk);
    data_req = 1'b1; data_addr = a; data_we = w; data_be = b; data_wdata = wd;
    #1;
    check({name, ".gnt"}, {31'h0, data_gnt}, 32'h1);
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      data_req    = 1'b0;
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      apb.prdata  = 32'h5A5A_5A5A;
      if (apb.psel && !apb.penable) setup_seen = 1'b1;
      if (apb.psel && apb.penable) begin
        if (apb.paddr !== a) addr_ok = 1'b0;
        if (w && apb.pwdata !== wd) wd_ok = 1'b0;
        if (apb.pwrite !== w) wr_ok = 1'b0;
        if (acc == waits) begin
          apb.pready  = 1'b1;
          apb.prdata  = srd;
          apb.pslverr = serr;
        end
        acc++;
      end
      if (data_rvalid) begin
        done    = 1'b1;
        got_rd  = data_rdata;
        got_err = data_err;
      end
    end
    check({name, ".lat"},   32'(k),   32'(exp_lat));
    check({name, ".acc"},   32'(acc), 32'(exp_acc));
    check({name, ".rdata"}, got_rd,   exp_rd);
    check({name, ".err"},   {31'h0, got_err}, {31'h0, exp_err});
    check({name, ".setup"}, {31'h0, setup_seen}, {31'h0, (exp_acc > 0)});
    check({name, ".paddr"}, {31'h0, addr_ok}, 32'h1);
    check({name, ".pwdata"}, {31'h0, wd_ok}, 32'h1);
    check({name, ".pwrite"}, {31'h0, wr_ok}, 32'h1);
    @(negedge clk);
    check({name, ".pulse"}, {31'h0, data_rvalid}, 32'h0);
    check({name, ".idle_psel"}, {31'h0, apb.psel}, 32'h0);
    $display("TXN %s addr=%h we=%b be=%h lat=%0d acc=%0d rdata=%h err=%b",
             name, a, w, b, k, acc, got_rd, got_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rv_seen;
    rst = 1'b1; data_req = 1'b0; data_addr = 32'h0; data_we = 1'b0;
    data_be = 4'h0; data_wdata = 32'h0;
    apb.pready = 1'b0; apb.prdata = 32'h0; apb.pslverr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.psel",    {31'h0, apb.psel},    32'h0);
    check("rst.penable", {31'h0, apb.penable}, 32'h0);
    check("rst.pwrite",  {31'h0, apb.pwrite},  32'h0);
    check("rst.paddr",   apb.paddr,            32'h0);
    check("rst.pwdata",  apb.pwdata,           32'h0);
    check("rst.rvalid",  {31'h0, data_rvalid}, 32'h0);
    check("rst.err",     {31'h0, data_err},    32'h0);
    check("rst.rdata",   data_rdata,           32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.gnt", {31'h0, data_gnt}, 32'h0);

    run_txn("rd_zero_wait", 32'h1A10_3004, 1'b0, 4'hF, 32'h0, 0,
            32'h0000_00A5, 1'b0, 4, 1, 32'h0000_00A5, 1'b0);
    run_txn("wr_3wait", 32'h1A10_1008, 1'b1, 4'hF, 32'hCAFE_F00D, 3,
            32'hFFFF_FFFF, 1'b0, 7, 4, 32'h0, 1'b0);
    check("hold.paddr",  apb.paddr,  32'h1A10_1008);
    check("hold.pwdata", apb.pwdata, 32'hCAFE_F00D);
    run_txn("rd_out_win", 32'h2000_0000, 1'b0, 4'hF, 32'h0, 0,
            32'h0, 1'b0, 2, 0, 32'hBADA_CCE5, 1'b1);
    run_txn("wr_part_be", 32'h1A10_0040, 1'b1, 4'h3, 32'h1111_2222, 0,
            32'h0, 1'b0, 2, 0, 32'hBADA_CCE5, 1'b1);
    run_txn("rd_win_top", 32'h1A11_FFFC, 1'b0, 4'hF, 32'h0, 0,
            32'h0000_0042, 1'b0, 4, 1, 32'h0000_0042, 1'b0);
    run_txn("rd_timeout", 32'h1A10_2000, 1'b0, 4'hF, 32'h0, 100,
            32'h0, 1'b0, 19, 16, 32'hBADA_CCE5, 1'b1);
    run_txn("rd_late_rdy", 32'h1A10_2004, 1'b0, 4'hF, 32'h0, 15,
            32'h1234_5678, 1'b0, 19, 16, 32'h1234_5678, 1'b0);
    run_txn("rd_slverr", 32'h1A10_0100, 1'b0, 4'hF, 32'h0, 1,
            32'h0000_0077, 1'b1, 5, 2, 32'h0000_0077, 1'b1);

    // Reset while the bridge is waiting in ACCESS.
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h1A10_0010; data_we = 1'b0; data_be = 4'hF;
    @(negedge clk);
    data_req = 1'b0;
    @(negedge clk);
    check("abort.in_access", {31'h0, apb.penable}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.psel",    {31'h0, apb.psel},    32'h0);
    check("abort.penable", {31'h0, apb.penable}, 32'h0);
    rv_seen = data_rvalid;
    repeat (4) begin
      @(negedge clk);
      rv_seen = rv_seen | data_rvalid;
    end
    check("abort.no_rvalid", {31'h0, rv_seen}, 32'h0);
    $display("TXN abort_in_access rvalid_seen=%b", rv_seen);
    run_txn("rd_after_rst", 32'h1A10_0010, 1'b0, 4'hF, 32'h0, 0,
            32'h0000_0C0D, 1'b0, 4, 1, 32'h0000_0C0D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_req_bridge.md
Name: apb_req_bridge

Overview:
- Bridges the core/AXI-side single-outstanding req/gnt/rvalid data port onto the peripheral APB bus and drives the `APB_BUS.Master` modport.
- Performs APB3 SETUP/ACCESS sequencing and checks the address window.
- Applies a PREADY timeout so a hung slave cannot stall the core.
- Sits directly upstream of the peripheral APB decoder (UART/GPIO/SPI/TIMER/... at 0x1A10_0000–0x1A11_FFFF).

Parameters:
- `WIN_BASE`, default 32'h1A10_0000: base of the accepted APB address window.
- `WIN_MASK`, default 32'hFFFE_0000: an address is in the window iff `(addr & WIN_MASK) == WIN_BASE`.
- `TIMEOUT`, default 16: maximum ACCESS cycles waiting for `pready`. A value of 0 disables the timeout.
- `ERR_RDATA`, default 32'hBADA_CCE5: `data_rdata_o` value returned on any bridge-generated error.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_req_i`  in  1  request valid.
- `data_addr_i`  in  32  byte address.
- `data_we_i`  in  1  1 = write.
- `data_be_i`  in  4  byte enables.
- `data_wdata_i`  in  32  write data.
- `data_gnt_o`  out  1  request accepted (combinational in IDLE).
- `data_rvalid_o`  out  1  response valid, one-cycle pulse.
- `data_rdata_o`  out  32  read data, valid with `rvalid`.
- `data_err_o`  out  1  error flag, valid with `rvalid`.
- `apb_master`  if  -  `APB_BUS.Master` modport (32-bit address, 32-bit data).

Behaviour:
- Interface facts (already decided):
  - One clock, `clk`.
  - Reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - `psel`, `penable`, `pwrite` = 0.
  - `paddr`, `pwdata` = 0.
  - `data_rvalid_o`, `data_err_o` = 0.
  - `data_rdata_o` = 0.
  - timeout counter = 0.
- All APB outputs and all response outputs are registered. `data_gnt_o` is the only combinational output: it equals `(state==IDLE) && data_req_i`.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On `data_req_i`: assert gnt and capture addr/we/wdata.
  - If the address is outside the window, or the request is a write with `data_be_i != 4'hF`: go to RESP with err=1 and rdata=`ERR_RDATA`. No APB transfer is issued.
  - Otherwise go to SETUP.
- SETUP: `psel=1`, `penable=0`, with paddr/pwdata/pwrite stable from the captured values. Lasts exactly one cycle, then ACCESS.
- ACCESS:
  - `psel=1`, `penable=1`; the counter increments each cycle.
  - If `pready=1`: capture `prdata` (reads; writes return 0) and `pslverr` into the response registers, then go to RESP.
  - Else, if `TIMEOUT!=0` and the counter equals `TIMEOUT-1`: go to RESP with err=1 and rdata=`ERR_RDATA`.
  - If `pready` arrives in the same cycle as the timeout, `pready` wins.
- RESP:
  - `psel=0`, `penable=0`.
  - `data_rvalid_o=1` for exactly one cycle, then IDLE. The counter clears.
  - No gnt in RESP, so there is never more than one transaction outstanding.
- Latency:
  - A zero-wait slave gives gnt at cycle 0, SETUP at 1, ACCESS at 2, `rvalid` at 4 (measured from the gnt edge to the `rvalid` cycle).
  - Each wait state adds one cycle.
  - A window/be error gives `rvalid` 2 cycles after gnt.
- `paddr`, `pwdata` and `pwrite` hold their values between transfers; they are not cleared after a transfer.
- `pready` and `prdata` are ignored outside ACCESS.
- `data_req_i` dropped after gnt has no effect on the transaction in flight.
- Reset mid-transfer: the next edge returns to IDLE and drops `psel`/`penable`. No `rvalid` is emitted for the aborted transfer.
- Counter width is `$clog2(TIMEOUT+1)`; the counter never wraps because it is cleared on leaving ACCESS.

Decomposition:
- Package `apb_bridge_pkg` holds:
  - the `bridge_state_e` enum (IDLE/SETUP/ACCESS/RESP);
  - the default `WIN_BASE`/`WIN_MASK`;
  - `ERR_RDATA`;
  - an `in_window(addr, base, mask)` function.
- One sub-module is natural: `apb_timeout_cnt`, a parameterised counter with clear/enable inputs and an `expired` output.

Test Plan:
- Zero-wait read at 32'h1A10_3004 with slave `prdata`=32'h0000_00A5, `pready`=1 -> SETUP then ACCESS with paddr 32'h1A10_3004; `rvalid` at gnt+4 with rdata 32'h0000_00A5, err=0.
- Write 32'hCAFE_F00D to 32'h1A10_1008 with be=4'hF and a slave 3 wait states -> `pwrite=1`, `pwdata` stable across 4 ACCESS cycles; `rvalid` at gnt+7, err=0.
- Read at 32'h2000_0000 (outside window) -> no `psel` ever; `rvalid` at gnt+2, err=1, rdata 32'hBADA_CCE5.
- Write with be=4'h3 -> no APB transfer; err=1 response.
- `pready` held 0 with `TIMEOUT`=16 -> exactly 16 ACCESS cycles, then `rvalid` with err=1 and rdata 32'hBADA_CCE5. With `pready` rising in cycle 16 instead -> normal response, err=`pslverr`.
- Assert `rst` during ACCESS -> `psel`/`penable` are 0 the next cycle, no `rvalid`. A subsequent read then completes normally.
- Slave `pslverr`=1 on a read -> err=1 and rdata equal to the slave's `prdata`.
